// File: rtl/mod_counter.sv
// Purpose : parametrised synchronous modulo counter (up/down, enable, load, clear, wrap/saturate).
// Latency : one cycle; inputs sampled on a rising clk edge appear on q/wrap/ovf right after that edge.
// Backpr. : none; the counter accepts a command on every edge and never stalls.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset (q, wrap, ovf, q_gray -> 0)
//   clr       synchronous clear, highest priority (q, wrap, ovf -> 0)
//   load      synchronous load of min(load_val, MAX_VAL); ovf untouched
//   load_val  load data
//   en        count enable (lowest priority after clr/load)
//   up        count direction, 1 = increment, 0 = decrement
//   q         registered count, always within 0..MAX_VAL
//   wrap      registered one-cycle pulse after a boundary step
//   ovf       registered sticky boundary flag, cleared only by clr or rst
//   q_gray    registered Gray code of q (only when COUNTER_GRAY_EN is defined)
//
// Optional feature macro: COUNTER_GRAY_EN adds the q_gray output and its register.
// Parameter legality: WIDTH >= 2, 1 <= MAX_VAL <= 2**WIDTH-1.
module mod_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             ovf
`ifdef COUNTER_GRAY_EN
    ,
    output logic [WIDTH-1:0] q_gray
`endif
);

    // Terminal value at counter width; all comparisons stay in WIDTH bits so the
    // arithmetic is modulo MAX_VAL+1 rather than modulo 2**WIDTH.
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] next_q;
    logic             next_wrap;
    logic             next_ovf;
    logic             at_top;
    logic             at_bot;
    logic [WIDTH-1:0] load_clamped;

    assign at_top       = (q == MAX_Q);
    assign at_bot       = (q == '0);
    assign load_clamped = (load_val > MAX_Q) ? MAX_Q : load_val;

    // Priority: clr > load > en > hold. wrap defaults low so it can only be a
    // single-cycle pulse unless a saturating counter keeps hitting the boundary.
    always_comb begin
        next_q    = q;
        next_wrap = 1'b0;
        next_ovf  = ovf;
        if (clr) begin
            next_q   = '0;
            next_ovf = 1'b0;
        end else if (load) begin
            next_q = load_clamped;
        end else if (en) begin
            if (up) begin
                if (at_top) begin
                    next_q    = SATURATE ? MAX_Q : '0;
                    next_wrap = 1'b1;
                    next_ovf  = 1'b1;
                end else begin
                    next_q = q + 1'b1;
                end
            end else begin
                if (at_bot) begin
                    next_q    = SATURATE ? '0 : MAX_Q;
                    next_wrap = 1'b1;
                    next_ovf  = 1'b1;
                end else begin
                    next_q = q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            q    <= next_q;
            wrap <= next_wrap;
            ovf  <= next_ovf;
        end
    end

`ifdef COUNTER_GRAY_EN
    // Encoded from next_q so q_gray is the Gray code of q in the same cycle,
    // without an extra pipeline stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_gray <= '0;
        end else begin
            q_gray <= next_q ^ (next_q >> 1);
        end
    end
`endif

endmodule

// File: tb/tb_mod_counter.sv
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       up;

    // w: WIDTH=4 MAX=9 wrap; s: WIDTH=4 MAX=9 saturate; f: WIDTH=4 MAX=15 wrap
    logic [3:0] qw, qs, qf;
    logic       ww, ws, wf;
    logic       ow, os, of_;
`ifdef COUNTER_GRAY_EN
    logic [3:0] gw, gs, gf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .q(qw), .wrap(ww), .ovf(ow)
`ifdef COUNTER_GRAY_EN
        , .q_gray(gw)
`endif
    );

    mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .q(qs), .wrap(ws), .ovf(os)
`ifdef COUNTER_GRAY_EN
        , .q_gray(gs)
`endif
    );

    mod_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1'b0)) u_full (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .q(qf), .wrap(wf), .ovf(of_)
`ifdef COUNTER_GRAY_EN
        , .q_gray(gf)
`endif
    );

    typedef struct {
        logic       clr;
        logic       load;
        logic [3:0] lv;
        logic       en;
        logic       up;
        logic [3:0] wq;
        logic       ww;
        logic       wo;
        logic [3:0] sq;
        logic       sw;
        logic       so;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic c, input logic l, input logic [3:0] lv,
                       input logic e, input logic u,
                       input logic [3:0] wq, input logic wwr, input logic wo,
                       input logic [3:0] sq, input logic swr, input logic so);
        vec_t v;
        v.clr = c; v.load = l; v.lv = lv; v.en = e; v.up = u;
        v.wq = wq; v.ww = wwr; v.wo = wo; v.sq = sq; v.sw = swr; v.so = so;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive a command after the falling edge, then sample 1 time unit after the rising edge.
    task automatic drive(input logic c, input logic l, input logic [3:0] lv,
                         input logic e, input logic u);
        @(negedge clk);
        clr = c; load = l; load_val = lv; en = e; up = u;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] eq;
        logic [3:0] eg;
        logic [3:0] pg;

        rst = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; up = 1'b1;

        // ---------------- vector table ----------------
        //   clr load lv en up | wq ww wo | sq sw so
        for (int i = 1; i <= 9; i++)
            add(0, 0, 0, 1, 1, 4'(i), 0, 0, 4'(i), 0, 0);
        add(0, 0, 0,  1, 1,  0, 1, 1,  9, 1, 1);   // boundary: wrap to 0 / hold 9
        add(0, 0, 0,  1, 1,  1, 0, 1,  9, 1, 1);   // saturate re-pulses wrap
        add(0, 0, 0,  0, 1,  1, 0, 1,  9, 0, 1);   // hold
        add(0, 1, 0,  0, 1,  0, 0, 1,  0, 0, 1);   // load 0, ovf kept
        add(0, 0, 0,  1, 0,  9, 1, 1,  0, 1, 1);   // down at 0
        add(0, 0, 0,  1, 0,  8, 0, 1,  0, 1, 1);
        add(0, 1, 9,  0, 1,  9, 0, 1,  9, 0, 1);   // load 9
        add(0, 0, 0,  1, 1,  0, 1, 1,  9, 1, 1);
        add(0, 0, 0,  1, 1,  1, 0, 1,  9, 1, 1);
        add(0, 0, 0,  1, 1,  2, 0, 1,  9, 1, 1);
        add(0, 0, 0,  1, 0,  1, 0, 1,  8, 0, 1);   // turn around, no dead cycle
        add(0, 1, 12, 0, 1,  9, 0, 1,  9, 0, 1);   // clamp
        add(0, 1, 15, 0, 1,  9, 0, 1,  9, 0, 1);   // clamp
        add(1, 1, 5,  1, 1,  0, 0, 0,  0, 0, 0);   // clr beats load and en
        add(0, 1, 7,  1, 1,  7, 0, 0,  7, 0, 0);   // load beats en
        add(0, 0, 0,  1, 1,  8, 0, 0,  8, 0, 0);
        add(0, 0, 0,  1, 0,  7, 0, 0,  7, 0, 0);
        add(1, 0, 0,  0, 1,  0, 0, 0,  0, 0, 0);
        add(0, 0, 0,  1, 0,  9, 1, 1,  0, 1, 1);   // first wrap sets ovf
        add(1, 0, 0,  1, 0,  0, 0, 0,  0, 0, 0);   // clr clears wrap and ovf

        // ---------------- reset state ----------------
        #12;
        check("rst qw", qw, 0);  check("rst ww", ww, 0);  check("rst ow", ow, 0);
        check("rst qs", qs, 0);  check("rst qf", qf, 0);  check("rst of", of_, 0);
`ifdef COUNTER_GRAY_EN
        check("rst gf", gf, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[i]) begin
            drive(vq[i].clr, vq[i].load, vq[i].lv, vq[i].en, vq[i].up);
            check($sformatf("v%0d qw", i), qw, vq[i].wq);
            check($sformatf("v%0d ww", i), ww, vq[i].ww);
            check($sformatf("v%0d ow", i), ow, vq[i].wo);
            check($sformatf("v%0d qs", i), qs, vq[i].sq);
            check($sformatf("v%0d ws", i), ws, vq[i].sw);
            check($sformatf("v%0d os", i), os, vq[i].so);
`ifdef COUNTER_GRAY_EN
            eq = vq[i].wq;
            check($sformatf("v%0d gw", i), gw, eq ^ (eq >> 1));
`endif
        end

        // ---------------- asynchronous reset mid-count ----------------
        drive(0, 1, 9, 0, 1);
        drive(0, 0, 0, 1, 1);
        check("pre-rst ww", ww, 1);
        check("pre-rst ow", ow, 1);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 1);
        check("pre-rst qw", qw, 5);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst qw", qw, 0);
        check("async rst ww", ww, 0);
        check("async rst ow", ow, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post-rst qw", qw, 1);
        check("post-rst qs", qs, 1);

        // ---------------- full-range up count on MAX=15 ----------------
        drive(1, 0, 0, 0, 1);
        check("full clr qf", qf, 0);
        pg = 4'd0;
        for (int i = 1; i <= 16; i++) begin
            drive(0, 0, 0, 1, 1);
            eq = 4'(i % 16);
            eg = eq ^ (eq >> 1);
            check($sformatf("full%0d qf", i), qf, eq);
            check($sformatf("full%0d wf", i), wf, (i == 16) ? 1 : 0);
            check($sformatf("full%0d of", i), of_, (i == 16) ? 1 : 0);
`ifdef COUNTER_GRAY_EN
            check($sformatf("full%0d gf", i), gf, eg);
            check($sformatf("full%0d hd", i), $countones(gf ^ pg), 1);
            pg = gf;
`else
            pg = eg;
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
